// File: rtl/gray_decoder_monitor.sv
// Gray-code receive monitor: decodes sampled Gray codes and checks single-step motion.
// Optional step counter output Step_cnt when GRAY_DEC_STEPCNT_EN is defined.
module gray_decoder_monitor #(
    parameter int WIDTH = 3
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             En,
    input  logic             Clear,
    input  logic [WIDTH-1:0] Gray_in,
    output logic [WIDTH-1:0] Binary,
    output logic             Valid,
    output logic             Dir,
    output logic             Step_err,
    output logic             Error,
    output logic             Overflow,
`ifdef GRAY_DEC_STEPCNT_EN
    output logic             Underflow,
    output logic [15:0]      Step_cnt
`else
    output logic             Underflow
`endif
);

    typedef enum logic [1:0] {IDLE, TRACK, ERR} state_t;

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ONES = '1;

    state_t           state;
    logic [WIDTH-1:0] dec;
    logic [WIDTH-1:0] delta;

    // Each binary bit is the parity of the Gray bits at and above it.
    for (genvar i = 0; i < WIDTH; i++) begin : g_dec
        assign dec[i] = ^Gray_in[WIDTH-1:i];
    end

    assign delta = dec - Binary;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            Binary    <= '0;
            Valid     <= 1'b0;
            Dir       <= 1'b0;
            Step_err  <= 1'b0;
            Error     <= 1'b0;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
`ifdef GRAY_DEC_STEPCNT_EN
            Step_cnt  <= '0;
`endif
        end else if (Clear) begin
            state     <= IDLE;
            Binary    <= '0;
            Valid     <= 1'b0;
            Dir       <= 1'b0;
            Step_err  <= 1'b0;
            Error     <= 1'b0;
            Overflow  <= 1'b0;
            Underflow <= 1'b0;
`ifdef GRAY_DEC_STEPCNT_EN
            Step_cnt  <= '0;
`endif
        end else begin
            Step_err <= 1'b0;
            if (En) begin
                case (state)
                    IDLE: begin
                        Binary <= dec;
                        Valid  <= 1'b1;
                        state  <= TRACK;
                    end
                    TRACK: begin
                        if (delta == ONE) begin
                            Binary <= dec;
                            Dir    <= 1'b1;
                            if (Binary == ONES) Overflow <= 1'b1;
`ifdef GRAY_DEC_STEPCNT_EN
                            if (Step_cnt != 16'hFFFF) Step_cnt <= Step_cnt + 16'd1;
`endif
                        end else if (delta == ONES) begin
                            Binary <= dec;
                            Dir    <= 1'b0;
                            if (Binary == '0) Underflow <= 1'b1;
`ifdef GRAY_DEC_STEPCNT_EN
                            if (Step_cnt != 16'hFFFF) Step_cnt <= Step_cnt + 16'd1;
`endif
                        end else if (delta != '0) begin
                            Binary   <= dec;
                            Step_err <= 1'b1;
                            Error    <= 1'b1;
                            state    <= ERR;
                        end
                    end
                    // Keep following the input but stop judging it until cleared.
                    ERR: Binary <= dec;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_gray_decoder_monitor.sv
// Randomized + directed bench for gray_decoder_monitor against an arithmetic reference model.
module tb_gray_decoder_monitor;
    localparam int W = 3;
    localparam int N = 1 << W;

    logic         Clk = 1'b0;
    logic         Reset_n = 1'b0;
    logic         En = 1'b0;
    logic         Clear = 1'b0;
    logic [W-1:0] Gray_in = '0;
    logic [W-1:0] Binary;
    logic         Valid, Dir, Step_err, Error, Overflow, Underflow;
`ifdef GRAY_DEC_STEPCNT_EN
    logic [15:0]  Step_cnt;
`endif

    gray_decoder_monitor #(.WIDTH(W)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .En(En), .Clear(Clear), .Gray_in(Gray_in),
        .Binary(Binary), .Valid(Valid), .Dir(Dir), .Step_err(Step_err),
        .Error(Error), .Overflow(Overflow),
`ifdef GRAY_DEC_STEPCNT_EN
        .Underflow(Underflow), .Step_cnt(Step_cnt)
`else
        .Underflow(Underflow)
`endif
    );

    always #5 Clk = ~Clk;

    int errors = 0;
    int checks = 0;

    // reference model state
    int m_bin, m_valid, m_dir, m_serr, m_err, m_ovf, m_unf, m_cnt, m_stuck;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int gdec(input int g);
        int b = 0;
        for (int s = 0; s < W; s++) b = b ^ (g >> s);
        return b % N;
    endfunction

    function automatic int genc(input int b);
        return (b ^ (b >> 1)) % N;
    endfunction

    task automatic m_zero();
        m_bin = 0; m_valid = 0; m_dir = 0; m_serr = 0;
        m_err = 0; m_ovf = 0; m_unf = 0; m_cnt = 0; m_stuck = 0;
    endtask

    task automatic m_step(input int en, input int clr, input int g);
        int d, delta;
        if (clr != 0) begin
            m_zero();
            return;
        end
        m_serr = 0;
        if (en == 0) return;
        d = gdec(g);
        if (m_valid == 0) begin
            m_bin = d; m_valid = 1;
        end else if (m_stuck != 0) begin
            m_bin = d;
        end else begin
            delta = (d - m_bin + N) % N;
            if (delta == 1) begin
                if (m_bin == N - 1) m_ovf = 1;
                m_bin = d; m_dir = 1;
                if (m_cnt < 65535) m_cnt++;
            end else if (delta == N - 1) begin
                if (m_bin == 0) m_unf = 1;
                m_bin = d; m_dir = 0;
                if (m_cnt < 65535) m_cnt++;
            end else if (delta != 0) begin
                m_bin = d; m_serr = 1; m_err = 1; m_stuck = 1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".Binary"}, 32'(Binary), 32'(m_bin));
        chk({tag, ".Valid"}, 32'(Valid), 32'(m_valid));
        chk({tag, ".Dir"}, 32'(Dir), 32'(m_dir));
        chk({tag, ".Step_err"}, 32'(Step_err), 32'(m_serr));
        chk({tag, ".Error"}, 32'(Error), 32'(m_err));
        chk({tag, ".Overflow"}, 32'(Overflow), 32'(m_ovf));
        chk({tag, ".Underflow"}, 32'(Underflow), 32'(m_unf));
`ifdef GRAY_DEC_STEPCNT_EN
        chk({tag, ".Step_cnt"}, 32'(Step_cnt), 32'(m_cnt));
`endif
    endtask

    task automatic cyc(input string tag, input int en, input int clr, input int g);
        En = 1'(en); Clear = 1'(clr); Gray_in = W'(g);
        @(posedge Clk);
        m_step(en, clr, g);
        #1;
        check_all(tag);
    endtask

    initial begin
        int seq2 [9] = '{0, 1, 3, 2, 6, 7, 5, 4, 0};
        int nb, r;
        m_zero();
        #12;
        check_all("reset");
        @(negedge Clk) Reset_n = 1'b1;

        // async reset mid-run
        cyc("pre_a", 1, 0, 3'b000);
        cyc("pre_b", 1, 0, 3'b001);
        #2 Reset_n = 1'b0;
        m_zero();
        #1 check_all("async_rst");
        @(negedge Clk) Reset_n = 1'b1;
        cyc("post_rst", 1, 0, 3'b101);
        chk("post_rst.valid", 32'(Valid), 1);
        chk("post_rst.serr", 32'(Step_err), 0);

        // full up count with wrap
        cyc("t2_clr", 0, 1, 0);
        foreach (seq2[i]) cyc("t2", 1, 0, seq2[i]);
        chk("t2.bin", 32'(Binary), 0);
        chk("t2.dir", 32'(Dir), 1);
        chk("t2.ovf", 32'(Overflow), 1);
        chk("t2.err", 32'(Error), 0);
`ifdef GRAY_DEC_STEPCNT_EN
        chk("t2.cnt", 32'(Step_cnt), 8);
`endif

        // down wrap
        cyc("t3_clr", 0, 1, 0);
        cyc("t3", 1, 0, 3'b000);
        cyc("t3", 1, 0, 3'b100);
        chk("t3.bin", 32'(Binary), 7);
        chk("t3.dir", 32'(Dir), 0);
        chk("t3.unf", 32'(Underflow), 1);
        chk("t3.ovf", 32'(Overflow), 0);

        // illegal jump
        cyc("t4_clr", 0, 1, 0);
        cyc("t4", 1, 0, 3'b000);
        cyc("t4", 1, 0, 3'b001);
        cyc("t4", 1, 0, 3'b110);
        chk("t4.serr", 32'(Step_err), 1);
        chk("t4.err", 32'(Error), 1);
        chk("t4.bin", 32'(Binary), 4);
        cyc("t4", 0, 0, 3'b110);
        chk("t4.serr_pulse", 32'(Step_err), 0);
        cyc("t4", 1, 0, 3'b010);
        chk("t4.bin2", 32'(Binary), 3);
        chk("t4.dir", 32'(Dir), 1);
        chk("t4.unf", 32'(Underflow), 0);

        // Clear beats En
        cyc("t5", 1, 1, 3'b011);
        chk("t5.valid", 32'(Valid), 0);
        chk("t5.bin", 32'(Binary), 0);
        cyc("t5", 1, 0, 3'b111);
        chk("t5.bin2", 32'(Binary), 5);
        chk("t5.serr", 32'(Step_err), 0);

        // repeated samples
        cyc("t6_clr", 0, 1, 0);
        for (int i = 0; i < 4; i++) cyc("t6", 1, 0, 3'b011);
        chk("t6.bin", 32'(Binary), 2);
        chk("t6.err", 32'(Error), 0);
`ifdef GRAY_DEC_STEPCNT_EN
        chk("t6.cnt", 32'(Step_cnt), 0);
`endif

        // randomized mostly-legal motion
        for (int i = 0; i < 500; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 4)      nb = (m_bin + 1) % N;
            else if (r < 7) nb = (m_bin + N - 1) % N;
            else if (r < 8) nb = m_bin;
            else            nb = int'($urandom_range(0, N - 1));
            cyc("rand", ($urandom_range(0, 3) != 0) ? 1 : 0,
                ($urandom_range(0, 39) == 0) ? 1 : 0, genc(nb));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
